// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and sequencer FSM states for the
// 32-bit ALU and its operation sequencer.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_NAND = 4'b0100;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_MOV  = 4'b1100;
  localparam logic [3:0] OP_ASR  = 4'b1101;

  // Flag vector is {Cout, Negative, Zero, Overflow}.
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULT = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_mult_ctrl.sv
// Shift-and-add multiply state: accumulator, shifted multiplicand, multiplier
// and step counter. The add itself is done by the external ALU.
module alu_mult_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MULT_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int CW = $clog2(MULT_STEPS + 1);

  logic [WIDTH-1:0] mplr;
  logic [CW-1:0]    cnt;

  // alu_y carries acc + mcand this cycle; keep it only when the multiplier bit is set.
  assign product = mplr[0] ? alu_y : acc;
  assign done    = step && (cnt == CW'(MULT_STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      acc   <= '0;
      mcand <= a;
      mplr  <= b;
      cnt   <= '0;
    end else if (step) begin
      acc   <= product;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command/response sequencer around an external combinational ALU.
// Multiply (opcode 1001) is built only when ALU_SEQ_MULT_EN is defined;
// otherwise that opcode returns an error response.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MULT_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_sel,
  input  logic             cmd_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err
);

  if (MULT_STEPS != WIDTH) begin : g_param_check
    $error("alu_op_sequencer: MULT_STEPS must equal WIDTH");
  end

  seq_state_t       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_sel;
  logic             op_cin;
  logic             accept;

  assign accept = cmd_valid && cmd_ready;

  function automatic logic op_legal(input logic [3:0] sel);
`ifdef ALU_SEQ_MULT_EN
    return sel <= OP_ASR;
`else
    return (sel <= OP_ASR) && (sel != OP_MUL);
`endif
  endfunction

`ifdef ALU_SEQ_MULT_EN
  logic [WIDTH-1:0] mult_acc;
  logic [WIDTH-1:0] mult_mcand;
  logic [WIDTH-1:0] mult_product;
  logic             mult_done;

  function automatic logic [3:0] mult_flags(input logic [WIDTH-1:0] y);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = y[WIDTH-1];
    f[FLAG_Z] = (y == '0);
    return f;
  endfunction

  alu_mult_ctrl #(
    .WIDTH      (WIDTH),
    .MULT_STEPS (MULT_STEPS)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && (cmd_sel == OP_MUL)),
    .step    (state == ST_MULT),
    .a       (cmd_a),
    .b       (cmd_b),
    .alu_y   (alu_y),
    .acc     (mult_acc),
    .mcand   (mult_mcand),
    .product (mult_product),
    .done    (mult_done)
  );

  // While multiplying, the ALU performs acc + mcand from the multiply registers.
  assign alu_a   = (state == ST_MULT) ? mult_acc   : op_a;
  assign alu_b   = (state == ST_MULT) ? mult_mcand : op_b;
  assign alu_sel = (state == ST_MULT) ? OP_ADD     : op_sel;
  assign alu_cin = (state == ST_MULT) ? 1'b0       : op_cin;
`else
  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_sel = op_sel;
  assign alu_cin = op_cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      op_cin    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a      <= cmd_a;
            op_b      <= cmd_b;
            op_sel    <= cmd_sel;
            op_cin    <= cmd_cin;
            cmd_ready <= 1'b0;
            if (!op_legal(cmd_sel)) begin
              state     <= ST_DONE;
              rsp_valid <= 1'b1;
              rsp_y     <= '0;
              rsp_flags <= '0;
              rsp_err   <= 1'b1;
`ifdef ALU_SEQ_MULT_EN
            end else if (cmd_sel == OP_MUL) begin
              state <= ST_MULT;
`endif
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          state     <= ST_DONE;
          rsp_valid <= 1'b1;
          rsp_y     <= alu_y;
          rsp_flags <= alu_flags;
          rsp_err   <= 1'b0;
        end
        ST_MULT: begin
`ifdef ALU_SEQ_MULT_EN
          if (mult_done) begin
            state     <= ST_DONE;
            rsp_valid <= 1'b1;
            rsp_y     <= mult_product;
            rsp_flags <= mult_flags(mult_product);
            rsp_err   <= 1'b0;
          end
`else
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
`endif
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU attached to the
// ALU ports, vector table, hand sequences and randomized commands.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_MULT_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_sel;
  logic        cmd_cin;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_sel, alu_flags;
  logic        alu_cin;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_y;
  logic [3:0]  rsp_flags;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Behavioural ALU: returns {y, Cout, Negative, Zero, Overflow}.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] sel, input logic cin);
    logic [32:0] s;
    logic [31:0] y;
    logic        c, v;
    s = '0; y = '0; c = 1'b0; v = 1'b0;
    case (sel)
      4'd0:  y = a & b;
      4'd1:  y = a | b;
      4'd2:  y = a ^ b;
      4'd3:  y = ~(a | b);
      4'd4:  y = ~(a & b);
      4'd5:  y = ~(a ^ b);
      4'd6: begin
        s = {1'b0, a} + {1'b0, b} + 33'(cin);
        y = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      4'd7: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        y = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      4'd8:  y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: y = a << b[4:0];
      4'd11: y = a >> b[4:0];
      4'd12: y = a;
      4'd13: y = $unsigned($signed(a) >>> b[4:0]);
      default: y = '0;
    endcase
    return {y, c, y[31], (y == 32'd0), v};
  endfunction

  always_comb {alu_y, alu_flags} = alu_fn(alu_a, alu_b, alu_sel, alu_cin);

  // Expected response {err, y, flags} from the command alone.
  function automatic logic [36:0] ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel, input logic cin);
    logic [31:0] p;
    if (sel >= 4'd14 || (sel == 4'd9 && !MUL_ON)) return {1'b1, 32'd0, 4'd0};
    if (sel == 4'd9) begin
      p = a * b;
      return {1'b0, p, 1'b0, p[31], (p == 32'd0), 1'b0};
    end
    return {1'b0, alu_fn(a, b, sel, cin)};
  endfunction

  function automatic int ref_lat(input logic [3:0] sel);
    if (sel >= 4'd14 || (sel == 4'd9 && !MUL_ON)) return 1;
    if (sel == 4'd9) return 33;
    return 2;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command, measure edges from accept to rsp_valid, capture response.
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                         input logic cin, input int hold,
                         output int lat, output logic [31:0] y, output logic [3:0] fl,
                         output logic er, output logic ready_seen);
    int guard;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_cin = cin; cmd_valid = 1'b1; rsp_ready = 1'b0;
    guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      nchk++; nerr++;
      $display("FAIL accept_timeout: cmd_ready stuck at 0");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    ready_seen = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      if (cmd_ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    y = rsp_y; fl = rsp_flags; er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      if (cmd_ready) ready_seen = 1'b1;
      @(negedge clk);
    end
    if (cmd_ready) ready_seen = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  sel;
    logic        cin;
    logic [31:0] y;
    logic [3:0]  fl;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          lat;
    logic [31:0] y;
    logic [3:0]  fl;
    logic        er, rs;
    logic [36:0] exp;
    int          acc_at[2];
    int          nacc, nrsp;
    logic [31:0] ry[2];
    logic        acc_now;

    vecs[0]  = '{32'd5, 32'd7, 4'b0110, 1'b0, 32'd12, 4'b0000, 1'b0, 2};
    vecs[1]  = '{32'd5, 32'd5, 4'b0111, 1'b0, 32'd0, 4'b1010, 1'b0, 2};
    vecs[2]  = '{32'h7FFF_FFFF, 32'd1, 4'b0110, 1'b0, 32'h8000_0000, 4'b0101, 1'b0, 2};
    vecs[3]  = '{32'hFFFF_FFFF, 32'd1, 4'b0110, 1'b0, 32'd0, 4'b1010, 1'b0, 2};
    vecs[4]  = '{32'd10, 32'd20, 4'b0110, 1'b1, 32'd31, 4'b0000, 1'b0, 2};
    vecs[5]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0000, 1'b0, 32'h00F0_00F0, 4'b0000, 1'b0, 2};
    vecs[6]  = '{32'h8000_0000, 32'd1, 4'b0001, 1'b0, 32'h8000_0001, 4'b0100, 1'b0, 2};
    vecs[7]  = '{32'hAAAA_AAAA, 32'hFFFF_FFFF, 4'b0010, 1'b0, 32'h5555_5555, 4'b0000, 1'b0, 2};
    vecs[8]  = '{32'h8000_0000, 32'd4, 4'b1101, 1'b0, 32'hF800_0000, 4'b0100, 1'b0, 2};
    vecs[9]  = '{32'd3, 32'd4, 4'b1110, 1'b0, 32'd0, 4'b0000, 1'b1, 1};
    vecs[10] = '{32'd3, 32'd4, 4'b1111, 1'b1, 32'd0, 4'b0000, 1'b1, 1};
`ifdef ALU_SEQ_MULT_EN
    vecs[11] = '{32'd3, 32'hFFFF_FFFF, 4'b1001, 1'b0, 32'hFFFF_FFFD, 4'b0100, 1'b0, 33};
`else
    vecs[11] = '{32'd3, 32'hFFFF_FFFF, 4'b1001, 1'b0, 32'd0, 4'b0000, 1'b1, 1};
`endif

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_cin = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset_rsp", {26'd0, rsp_valid, rsp_y, rsp_flags, rsp_err}, 64'd0);
    check("reset_alu_ports", {alu_a, alu_b[26:0], alu_sel, alu_cin}, 64'd0);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].cin, i % 3, lat, y, fl, er, rs);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_y", i), 64'(y), 64'(vecs[i].y));
      check($sformatf("vec%0d_flags", i), 64'(fl), 64'(vecs[i].fl));
      check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].err));
      check($sformatf("vec%0d_busy_ready", i), 64'(rs), 64'd0);
    end

    // Illegal opcode under backpressure, with another command waiting.
    @(negedge clk);
    cmd_a = 32'h1234; cmd_b = 32'h5678; cmd_sel = 4'b1111; cmd_cin = 1'b0; cmd_valid = 1'b1;
    check("bp_ready_before", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_sel = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d", k), {27'd0, rsp_valid, rsp_y, rsp_flags, rsp_err, cmd_ready},
            {27'd0, 1'b1, 32'd0, 4'd0, 1'b1, 1'b0});
      @(negedge clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_released", {62'd0, rsp_valid, cmd_ready}, 64'd1);

    // Reset while a multiply (or, without multiply, an error response) is in flight.
    @(negedge clk);
    cmd_a = 32'd9; cmd_b = 32'd9; cmd_sel = 4'b1001; cmd_cin = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_rsp", {26'd0, rsp_valid, rsp_y, rsp_flags, rsp_err}, 64'd0);
    check("abort_alu_ports", {alu_a, alu_b[26:0], alu_sel, alu_cin}, 64'd0);
    check("abort_ready", 64'(cmd_ready), 64'd1);
    rs = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (rsp_valid) rs = 1'b1;
      @(negedge clk);
    end
    check("abort_no_rsp", 64'(rs), 64'd0);
    run_cmd(32'd1, 32'd1, 4'b0110, 1'b0, 0, lat, y, fl, er, rs);
    check("post_abort_add_y", 64'(y), 64'd2);
    check("post_abort_add_lat", 64'(lat), 64'd2);

    // Back-to-back AND then OR with rsp_ready held high.
    @(negedge clk);
    cmd_a = 32'hFF00_FF00; cmd_b = 32'h0F0F_0F0F; cmd_sel = 4'b0000; cmd_cin = 1'b0;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    nacc = 0; nrsp = 0; acc_at[0] = -1; acc_at[1] = -1;
    for (int i = 0; i < 20 && nrsp < 2; i++) begin
      acc_now = cmd_valid && cmd_ready;
      if (rsp_valid && rsp_ready) begin
        ry[nrsp] = rsp_y;
        nrsp++;
      end
      if (acc_now) begin
        acc_at[nacc] = i;
        nacc++;
      end
      @(negedge clk);
      if (acc_now) begin
        if (nacc == 1) cmd_sel = 4'b0001;
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    check("b2b_rsp_count", 64'(nrsp), 64'd2);
    check("b2b_first_y", 64'(ry[0]), 64'h0F00_0F00);
    check("b2b_second_y", 64'(ry[1]), 64'hFF0F_FF0F);
    check("b2b_accept_gap", 64'(acc_at[1] - acc_at[0]), 64'd3);

    // Randomized commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic [3:0]  rsel;
      logic        rcin;
      ra = $urandom; rb = $urandom;
      if (i % 4 == 0) rb = $urandom_range(0, 40);
      rsel = 4'($urandom_range(0, 15));
      rcin = 1'($urandom_range(0, 1));
      exp = ref_rsp(ra, rb, rsel, rcin);
      run_cmd(ra, rb, rsel, rcin, $urandom_range(0, 2), lat, y, fl, er, rs);
      check($sformatf("rnd%0d_sel%0d_lat", i, rsel), 64'(lat), 64'(ref_lat(rsel)));
      check($sformatf("rnd%0d_sel%0d_y", i, rsel), 64'(y), 64'(exp[35:4]));
      check($sformatf("rnd%0d_sel%0d_flags", i, rsel), 64'(fl), 64'(exp[3:0]));
      check($sformatf("rnd%0d_sel%0d_err", i, rsel), 64'(er), 64'(exp[36]));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
